// File: rtl/array_feeder.sv
// array_feeder: transmit-side front end for a 4x4 systolic array.
// Buffers whole row vectors in a small FIFO and emits diagonally skewed lane
// streams (lane k delayed k steps) with input_en, followed by 3 zero drain
// steps and a one-cycle done pulse per matrix.
// Optional: define ARRAY_FEEDER_STALL_CNT_EN to add the stall_cnt output.
//
// Upstream handshake: a vector is taken on a rising edge where in_valid and
// in_ready are both high; in_ready is !full from the registered count only,
// and in_valid/in_data/in_last must stay stable until taken.
module array_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic                in_last,
  output logic                input_en,
  output logic [DATA_W-1:0]   a1_out,
  output logic [DATA_W-1:0]   a2_out,
  output logic [DATA_W-1:0]   a3_out,
  output logic [DATA_W-1:0]   a4_out,
`ifdef ARRAY_FEEDER_STALL_CNT_EN
  output logic [15:0]         stall_cnt,
`endif
  output logic                done
);

  localparam int AW = $clog2(DEPTH);
  localparam int VW = 4 * DATA_W + 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        drain_q, drain_d;
  logic [VW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic [DATA_W-1:0] sk1_q;
  logic [DATA_W-1:0] sk2_q [2];
  logic [DATA_W-1:0] sk3_q [3];
  logic [DATA_W-1:0] a_q [4];
  logic              en_q, done_q;

  logic              full, empty, push, pop, advance, pop_last;
  logic [VW-1:0]     head;
  logic [4*DATA_W-1:0] feed;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign in_ready = ~rst & ~full;
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == STREAM) & ~empty;
  assign advance  = pop | (state_q == DRAIN);
  assign head     = mem_q[rd_ptr_q];
  assign pop_last = head[VW-1];
  assign feed     = pop ? head[VW-2:0] : '0;

  assign input_en = en_q;
  assign a1_out   = a_q[0];
  assign a2_out   = a_q[1];
  assign a3_out   = a_q[2];
  assign a4_out   = a_q[3];
  assign done     = done_q;

  // FIFO storage; contents are don't-care once pointers reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // State and drain counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic: pop in STREAM, 3 drain steps, then one DONE cycle
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE:   if (!empty) state_d = STREAM;
      STREAM: if (pop && pop_last) begin
                state_d = DRAIN;
                drain_d = '0;
              end
      DRAIN:  begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'd2) state_d = DONE;
              end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Skew stages shift only on advance; outputs load lane values or zeros
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sk1_q  <= '0;
      for (int i = 0; i < 2; i++) sk2_q[i] <= '0;
      for (int i = 0; i < 3; i++) sk3_q[i] <= '0;
      for (int i = 0; i < 4; i++) a_q[i]   <= '0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      if (advance) begin
        a_q[0]   <= feed[0*DATA_W +: DATA_W];
        a_q[1]   <= sk1_q;
        a_q[2]   <= sk2_q[1];
        a_q[3]   <= sk3_q[2];
        sk1_q    <= feed[1*DATA_W +: DATA_W];
        sk2_q[1] <= sk2_q[0];
        sk2_q[0] <= feed[2*DATA_W +: DATA_W];
        sk3_q[2] <= sk3_q[1];
        sk3_q[1] <= sk3_q[0];
        sk3_q[0] <= feed[3*DATA_W +: DATA_W];
        en_q     <= 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) a_q[i] <= '0;
        en_q <= 1'b0;
      end
    end
  end

`ifdef ARRAY_FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;
  assign stall_cnt = stall_q;

  // Cycles starved in STREAM, saturating; cleared as done is raised
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == DONE) begin
      stall_q <= '0;
    end else if (state_q == STREAM && empty && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end
`endif

endmodule

// File: doc/array_feeder.md
Name: array_feeder

Overview:
- Transmit-side front end for the 4x4 systolic array.
- Accepts one 4-element row vector per handshake and buffers whole vectors in a small FIFO.
- Emits the diagonally skewed lane streams the array consumes: lane k is delayed k steps, and input_en is driven alongside the lanes.
- After each matrix, appends 3 zero drain steps and pulses done.

Parameters:
- DATA_W, 8, width of one element / one lane.
- DEPTH, 4, FIFO depth in vectors (power of 2, >=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous reset, active-high; clears all state.
- in_valid  in  1  upstream vector valid.
- in_ready  out  1  feeder can accept a vector; equals !full.
- in_data  in  4*DATA_W  packed vector; element k = in_data[k*DATA_W +: DATA_W].
- in_last  in  1  vector is the final row of the current matrix.
- input_en  out  1  lane data valid this cycle; drives array input_en.
- a1_out  out  DATA_W  lane 0 stream (array a1in).
- a2_out  out  DATA_W  lane 1 stream (array a2in).
- a3_out  out  DATA_W  lane 2 stream (array a3in).
- a4_out  out  DATA_W  lane 3 stream (array a4in).
- done  out  1  one-cycle pulse after the last drain step.

Behaviour:
- Reset values: in_ready=0 while rst is high, 1 after release (FIFO empty); input_en=0, a1_out..a4_out=0, done=0. FIFO count=0, skew stages=0, state=IDLE.
- FIFO push: on in_valid & in_ready. The {in_last, in_data} pair is stored. in_ready depends only on the registered count (full), never on a same-cycle pop.
- States:
  - IDLE: FIFO non-empty -> STREAM. Nothing popped in IDLE.
  - STREAM: advance = !empty. Each advance pops one vector. If the popped vector has last=1 -> DRAIN, drain counter=0.
  - DRAIN: advance=1 every cycle, feeding zeros into the skew. After the 3rd drain advance -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Skew pipeline: lane k has k internal stages that shift only on advance (stall holds them). Lane k at advance step s carries element k of the vector popped at step s-k, or 0 during drain.
- Outputs are registered. On an advance cycle the next edge loads lane values and sets input_en=1. Otherwise the next edge loads a*_out=0 and input_en=0 while skew contents are held.
- Underrun (STREAM, FIFO empty): stall. input_en=0, outputs 0, no state change; resumes on the next push with no data loss.
- Latency: vector pushed at edge E0 from IDLE -> a1_out valid at E2. For an unstalled M-row matrix, input_en is high for exactly M+3 consecutive cycles; done is high the cycle after the last one.
- Back-to-back matrices: the next matrix is not popped until IDLE is re-entered after done. Vectors may be pushed during DRAIN/DONE while not full.
- in_last on the first vector (M=1) is legal: 4 advances total.
- Reset mid-operation: all state is dropped immediately (async). FIFO contents are lost; outputs are 0 in the same cycle.

Optional Feature:
- Macro ARRAY_FEEDER_STALL_CNT_EN.
- Defined: adds output port stall_cnt [15:0]. It increments each cycle spent in STREAM with the FIFO empty, saturates at 16'hFFFF, clears on done and on rst.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset: rst=1 for 2 cycles -> input_en=0, a*_out=0, done=0, in_ready=0 during reset and 1 after release.
- Two-row matrix: push V0=(1,2,3,4) then V1=(5,6,7,8,last) from IDLE at E0/E1. Required lane values (a1,a2,a3,a4):
  - E2: (1,0,0,0)
  - E3: (5,2,0,0)
  - E4: (0,6,3,0)
  - E5: (0,0,7,4)
  - E6: (0,0,0,8)
  - input_en=1 E2..E6, done=1 at E7.
- Backpressure: with the consumer blocked in IDLE-free STREAM stall, push DEPTH+1 vectors with no last -> in_ready=0 after 4 pushes, 5th held. After a pop, in_ready=1 and the 5th is accepted in order.
- Underrun: push V0 only (no last), wait 5 cycles, then push V1 (last) -> input_en low during the gap, skew held; final lane sequence matches the unstalled case shifted by the gap. With ARRAY_FEEDER_STALL_CNT_EN, stall_cnt counts the gap cycles, then clears at done.
- Single-row matrix: push (9,9,9,9,last) -> input_en high 4 cycles; diagonal 9s on a1..a4 in successive cycles; then done.
- Reset mid-stream: assert rst during the 2nd drain cycle -> outputs 0 immediately, FIFO empty. A new matrix afterwards produces a clean sequence with no residue from before.
